wino_tile_sched: RTL

Tile scheduler for the Winograd PE array. A start pulse latches one layer configuration. The block then walks every output-channel group, input-tile position and input channel, and issues one tile "beat" per handshake to the data/weight tile buffers that feed the top and left edges of the array. After the last beat it waits for the PE pipeline to drain, then reports done.

---
 rtl/wino_tile_sched.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wino_tile_sched.sv
// wino_tile_sched: walks output-channel groups, input-tile positions and
// input channels for one layer and issues one tile beat per handshake to
// the data/weight tile buffers. After the last beat it waits for the PE
// array to drain, then pulses done_o.
// Optional feature: define WINO_SCHED_STALL_CNT_EN to build the
// saturating stall counter behind stall_cnt_o (tied to 0 otherwise).
module wino_tile_sched #(
  parameter int COLS         = 4,
  parameter int DRAIN_CYCLES = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [9:0]  cfg_img_h_i,
  input  logic [9:0]  cfg_img_w_i,
  input  logic [4:0]  cfg_in_ch_i,
  input  logic [7:0]  cfg_out_ch_i,
  input  logic        cfg_size_type_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        beat_valid_o,
  input  logic        beat_ready_i,
  output logic [8:0]  beat_x_o,
  output logic [8:0]  beat_y_o,
  output logic [3:0]  beat_id_o,
  output logic [7:0]  beat_od_o,
  output logic        beat_size_type_o,
  output logic        beat_first_o,
  output logic        beat_last_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [8:0]  COLS_W9    = 9'(COLS);
  localparam logic [7:0]  COLS_W8    = 8'(COLS);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  state_t      state_r, state_next_s;
  logic [9:0]  h_r, w_r;
  logic [4:0]  in_ch_r;
  logic [7:0]  out_ch_r;
  logic        size_r;
  logic [8:0]  x_r, y_r;
  logic [3:0]  id_r;
  logic [7:0]  od_r;
  logic        first_r, last_r;
  logic        valid_r, busy_r, done_r, err_r;
  logic [15:0] drain_cnt_r;

  logic [3:0]  stride_s;
  logic        cfg_ok_s;
  logic        accept_s;
  logic        adv_s;
  logic        id_wrap_s, x_wrap_s, y_wrap_s, od_wrap_s;
  logic        last_beat_s;
  logic        drain_end_s;

  // Loop-wrap and legality decodes; a tile wraps once its next step would start at or past the edge.
  assign stride_s    = size_r ? 4'd4 : 4'd6;
  assign cfg_ok_s    = (h_r != 10'd0) && (h_r <= 10'd512) &&
                       (w_r != 10'd0) && (w_r <= 10'd512) &&
                       (in_ch_r != 5'd0) && (in_ch_r <= 5'd16) &&
                       (out_ch_r != 8'd0) && (out_ch_r <= 8'd128);
  assign accept_s    = (state_r == S_IDLE) && start_i;
  assign adv_s       = valid_r && beat_ready_i;
  assign id_wrap_s   = ({1'b0, id_r} == (in_ch_r - 5'd1));
  assign x_wrap_s    = (({1'b0, x_r} + {6'd0, stride_s}) >= w_r);
  assign y_wrap_s    = (({1'b0, y_r} + {6'd0, stride_s}) >= h_r);
  assign od_wrap_s   = (({1'b0, od_r} + COLS_W9) >= {1'b0, out_ch_r});
  assign last_beat_s = adv_s && id_wrap_s && x_wrap_s && y_wrap_s && od_wrap_s;
  assign drain_end_s = (drain_cnt_r == DRAIN_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:  if (start_i)     state_next_s = S_LOAD;  else state_next_s = S_IDLE;
      S_LOAD:  if (cfg_ok_s)    state_next_s = S_RUN;   else state_next_s = S_DONE;
      S_RUN:   if (last_beat_s) state_next_s = S_DRAIN; else state_next_s = S_RUN;
      S_DRAIN: if (drain_end_s) state_next_s = S_DONE;  else state_next_s = S_DRAIN;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Latch the layer configuration only when a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_r      <= 10'd0;
      w_r      <= 10'd0;
      in_ch_r  <= 5'd0;
      out_ch_r <= 8'd0;
      size_r   <= 1'b0;
    end else if (accept_s) begin
      h_r      <= cfg_img_h_i;
      w_r      <= cfg_img_w_i;
      in_ch_r  <= cfg_in_ch_i;
      out_ch_r <= cfg_out_ch_i;
      size_r   <= cfg_size_type_i;
    end
  end

  // Nested loop counters (id innermost, od outermost); they move only on a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r  <= 9'd0;
      y_r  <= 9'd0;
      id_r <= 4'd0;
      od_r <= 8'd0;
    end else if (accept_s) begin
      x_r  <= 9'd0;
      y_r  <= 9'd0;
      id_r <= 4'd0;
      od_r <= 8'd0;
    end else if (adv_s) begin
      if (!id_wrap_s) begin
        id_r <= id_r + 4'd1;
      end else begin
        id_r <= 4'd0;
        if (!x_wrap_s) begin
          x_r <= x_r + {5'd0, stride_s};
        end else begin
          x_r <= 9'd0;
          if (!y_wrap_s) begin
            y_r <= y_r + {5'd0, stride_s};
          end else begin
            y_r <= 9'd0;
            if (!od_wrap_s) od_r <= od_r + COLS_W8;
            else            od_r <= 8'd0;
          end
        end
      end
    end
  end

  // Accumulator clear/writeback flags, registered to track the id of the beat on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else if ((state_r == S_LOAD) && cfg_ok_s) begin
      first_r <= 1'b1;
      last_r  <= (in_ch_r == 5'd1);
    end else if (last_beat_s) begin
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (adv_s) begin
      first_r <= id_wrap_s;
      last_r  <= id_wrap_s ? (in_ch_r == 5'd1) : (({1'b0, id_r} + 5'd2) == in_ch_r);
    end
  end

  // Registered status outputs, beat valid and the drain timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      drain_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            busy_r <= 1'b1;
            err_r  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (cfg_ok_s) begin
            valid_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
            err_r  <= 1'b1;
            done_r <= 1'b1;
          end
        end
        S_RUN: begin
          if (last_beat_s) begin
            valid_r     <= 1'b0;
            drain_cnt_r <= 16'd0;
          end
        end
        S_DRAIN: begin
          if (drain_end_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + 16'd1;
          end
        end
        S_DONE: done_r <= 1'b0;
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WINO_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Count cycles where a beat is offered but refused; saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                            stall_cnt_r <= 32'd0;
    else if (accept_s)                                    stall_cnt_r <= 32'd0;
    else if (valid_r && !beat_ready_i && (stall_cnt_r != 32'hFFFF_FFFF))
                                                          stall_cnt_r <= stall_cnt_r + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = 32'd0;
`endif

  assign busy_o           = busy_r;
  assign done_o           = done_r;
  assign err_o            = err_r;
  assign beat_valid_o     = valid_r;
  assign beat_x_o         = x_r;
  assign beat_y_o         = y_r;
  assign beat_id_o        = id_r;
  assign beat_od_o        = od_r;
  assign beat_size_type_o = size_r;
  assign beat_first_o     = first_r;
  assign beat_last_o      = last_r;

endmodule
